// File: rtl/rf_cmd_pkg.sv
// Shared types and the command-byte packer for the 1-byte UART register-file protocol.
package rf_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_BADRSP  = 2'b10
    } rsp_err_e;

    localparam logic [7:0] STRAY_MAX = 8'hFF;

    // Command byte is {we, addr, data}; data_w says where addr starts in the low 7 bits.
    function automatic logic [7:0] pack_cmd(input logic we, input logic [6:0] addr,
                                            input logic [6:0] data, input int unsigned data_w);
        logic [6:0] payload;
        payload = (addr << data_w) | data;
        return {we, payload};
    endfunction

endpackage

// File: rtl/rf_cmd_timer.sv
// Loadable down-counter used as the response timeout; stops at zero.
module rf_cmd_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rf_cmd_initiator.sv
// Host-side initiator: packs a register request into one UART byte, sends it,
// and waits (with timeout) for the single response byte.
module rf_cmd_initiator
    import rf_cmd_pkg::*;
#(
    parameter int unsigned RF_ADDR_WIDTH  = 3,
    parameter int unsigned RF_DATA_WIDTH  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [RF_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [RF_DATA_WIDTH-1:0] req_data_i,
    output logic                     rsp_valid_o,
    output logic [RF_DATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]               rsp_err_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [7:0]               tx_data_o,
    input  logic                     rx_valid_i,
    input  logic [7:0]               rx_data_i,
    output logic                     busy_o,
    output logic [7:0]               stray_cnt_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    if (RF_ADDR_WIDTH + RF_DATA_WIDTH != 7) begin : g_width_check
        $error("rf_cmd_initiator: RF_ADDR_WIDTH + RF_DATA_WIDTH must equal 7");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("rf_cmd_initiator: TIMEOUT_CYCLES must be at least 2");
    end

    state_e                   state_q;
    logic [7:0]               tx_data_q;
    logic                     rsp_valid_q;
    logic [RF_DATA_WIDTH-1:0] rsp_data_q;
    rsp_err_e                 rsp_err_q;
    logic [7:0]               stray_q;
    logic                     timer_zero;
    logic                     timer_load;
    logic                     timer_en;

    assign timer_load = (state_q == SEND) && tx_ready_i;
    assign timer_en   = (state_q == WAIT);

    rf_cmd_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .en_i       (timer_en),
        .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            stray_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            // Any rx byte that arrives while no command is outstanding is dropped and counted.
            if (rx_valid_i && (state_q != WAIT) && (stray_q != STRAY_MAX)) begin
                stray_q <= stray_q + 8'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        tx_data_q <= pack_cmd(req_we_i, 7'(req_addr_i),
                                              req_we_i ? 7'(req_data_i) : 7'd0, RF_DATA_WIDTH);
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A byte on the last timer cycle still counts as a valid response.
                    if (rx_valid_i) begin
                        rsp_data_q  <= rx_data_i[RF_DATA_WIDTH-1:0];
                        rsp_err_q   <= (rx_data_i[7:RF_DATA_WIDTH] != '0) ? ERR_BADRSP : ERR_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timer_zero) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign tx_valid_o  = (state_q == SEND);
    assign tx_data_o   = tx_data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign stray_cnt_o = stray_q;

endmodule

// File: tb/tb_rf_cmd_initiator.sv
// Directed plus randomized bench for rf_cmd_initiator with a transaction-level reference model.
module tb_rf_cmd_initiator;

    localparam int unsigned T = 16;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [2:0] req_addr;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic [1:0] rsp_err;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic [7:0] stray_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int stray_model = 0;

    rf_cmd_initiator #(
        .RF_ADDR_WIDTH  (3),
        .RF_DATA_WIDTH  (4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .busy_o      (busy),
        .stray_cnt_o (stray_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_stray();
        if (stray_model < 255) stray_model++;
    endtask

    task automatic send_stray(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        add_stray();
        tick();
        rx_valid = 1'b0;
        check("stray_no_rsp", 32'(rsp_valid), 32'd0);
        check("stray_cnt", 32'(stray_cnt), 32'(stray_model));
    endtask

    // One full request/response; starts and ends in IDLE at #1 after an edge.
    task automatic do_txn(input bit we, input logic [2:0] addr, input logic [3:0] data,
                          input int ready_dly, input bit use_rx, input int rx_dly,
                          input logic [7:0] rx_byte, input bit hold, input bit stray_in_resp);
        logic [7:0] exp_byte;
        int         lat;
        int         exp_d;
        int         exp_e;
        exp_byte = 8'((we ? 128 : 0) + int'(addr) * 16 + (we ? int'(data) : 0));
        if (use_rx && rx_dly < int'(T)) begin
            lat   = rx_dly + 1;
            exp_d = int'(rx_byte) % 16;
            exp_e = (int'(rx_byte) / 16 != 0) ? 2 : 0;
        end else begin
            lat   = T;
            exp_d = 0;
            exp_e = 1;
        end

        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        tx_ready  = 1'b0;
        tick();
        if (!hold) req_valid = 1'b0;
        check("send_tx_valid", 32'(tx_valid), 32'd1);
        check("send_tx_data", 32'(tx_data), 32'(exp_byte));
        check("send_ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < ready_dly; i++) begin
            tick();
            check("stall_tx_valid", 32'(tx_valid), 32'd1);
            check("stall_tx_data", 32'(tx_data), 32'(exp_byte));
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("wait_tx_valid", 32'(tx_valid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            check("wait_no_rsp", 32'(rsp_valid), 32'd0);
            check("wait_ready_low", 32'(req_ready), 32'd0);
            rx_valid = use_rx && (i == rx_dly);
            rx_data  = rx_byte;
            tick();
            rx_valid = 1'b0;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("rsp_err", 32'(rsp_err), 32'(exp_e));
        check("rsp_busy", 32'(busy), 32'd1);
        if (stray_in_resp) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            add_stray();
        end
        tick();
        rx_valid = 1'b0;
        check("post_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("post_rsp_data_held", 32'(rsp_data), 32'(exp_d));
        check("post_rsp_err_held", 32'(rsp_err), 32'(exp_e));
        check("post_rsp_busy", 32'(busy), 32'd0);
        check("post_rsp_stray", 32'(stray_cnt), 32'(stray_model));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_stray", 32'(stray_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Write addr 5 data A, immediate tx accept, echo 0x0A.
        do_txn(1'b1, 3'd5, 4'hA, 0, 1'b1, 2, 8'h0A, 1'b0, 1'b0);
        // Read addr 2 with data F ignored, tx stalled 3 cycles.
        do_txn(1'b0, 3'd2, 4'hF, 3, 1'b1, 0, 8'h07, 1'b0, 1'b0);
        // Timeout, then a late byte counts as stray.
        do_txn(1'b0, 3'd1, 4'h0, 0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        send_stray(8'h03);
        check("stray_after_timeout", 32'(stray_cnt), 32'd1);
        // Bad response, then rx on the final timeout cycle.
        do_txn(1'b0, 3'd4, 4'h0, 1, 1'b1, 5, 8'h35, 1'b0, 1'b0);
        do_txn(1'b1, 3'd7, 4'h3, 0, 1'b1, int'(T) - 1, 8'h09, 1'b0, 1'b0);

        // Held req_valid: second request accepted in the first IDLE cycle.
        do_txn(1'b1, 3'd3, 4'h6, 1, 1'b1, 3, 8'h06, 1'b1, 1'b1);
        do_txn(1'b0, 3'd6, 4'h1, 0, 1'b1, 1, 8'h0C, 1'b1, 1'b0);
        req_valid = 1'b0;
        tick();
        check("held_done_idle", 32'(busy), 32'd0);

        // Saturate the stray counter.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 300; i++) begin
            add_stray();
            tick();
        end
        rx_valid = 1'b0;
        check("stray_saturated", 32'(stray_cnt), 32'd255);
        check("stray_no_busy", 32'(busy), 32'd0);

        // Randomized transactions against the model.
        for (int n = 0; n < 30; n++) begin
            bit         r_we;
            logic [2:0] r_addr;
            logic [3:0] r_data;
            int         r_rdy;
            bit         r_use;
            int         r_dly;
            logic [7:0] r_byte;
            r_we   = 1'($urandom);
            r_addr = 3'($urandom);
            r_data = 4'($urandom);
            r_rdy  = int'($urandom_range(0, 3));
            r_use  = ($urandom_range(0, 4) != 0);
            r_dly  = int'($urandom_range(0, T - 1));
            r_byte = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            do_txn(r_we, r_addr, r_data, r_rdy, r_use, r_dly, r_byte, 1'b0,
                   ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of WAIT abandons the transaction immediately.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 3'd2;
        tick();
        req_valid = 1'b0;
        tx_ready  = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        stray_model = 0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        check("midrst_stray", 32'(stray_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_txn(1'b0, 3'd2, 4'h0, 1, 1'b1, 4, 8'h0E, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
